alu_op_sequencer: RTL and testbench

- Front-end controller for the 4-bit ALU datapath (adder, logic unit, shifter, ZNCV flags).
- Accepts ALU operations through a valid/ready queue and drives registered operands and function code into the combinational ALU.
- Captures the result and flags one cycle later and presents them on a valid/ready result port.
- Holds an accumulator so that an operation can chain on the previous result.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_fifo.sv | 41 ++++
 rtl/alu_op_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: function codes, FSM states,
// flag bit positions and the queue entry width.
package alu_seq_pkg;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_AND  = 4'b0100;
  localparam logic [3:0] FN_OR   = 4'b0101;
  localparam logic [3:0] FN_XOR  = 4'b0110;
  localparam logic [3:0] FN_SLL  = 4'b1000;
  localparam logic [3:0] FN_SRL  = 4'b1001;
  localparam logic [3:0] FN_SRA  = 4'b1010;
  localparam logic [3:0] FN_PASS = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Entry layout is {func, a, b, chain}.
  function automatic int entry_w(input int dw);
    return 4 + 2 * dw + 1;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO with registered storage; pointers carry one extra wrap bit
// so full and empty are distinguished without a counter.
module alu_seq_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU ops, drives registered operands into an external combinational ALU,
// captures result/flags one cycle later and hands them off on a valid/ready port.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW         = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_func,
  input  logic [DW-1:0]    op_a,
  input  logic [DW-1:0]    op_b,
  input  logic             op_chain,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [3:0]       alu_func,
  input  logic [DW-1:0]    alu_y,
  input  logic [3:0]       alu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data,
  output logic [3:0]       res_flags,
  output logic [DW-1:0]    acc_out,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int EW = entry_w(DW);

  typedef struct packed {
    logic [3:0]    func;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          chain;
  } entry_t;

  entry_t        wr_ent;
  entry_t        head;
  logic [EW-1:0] head_raw;
  logic          full;
  logic          empty;
  logic          pop;
  state_t        state;
  logic [DW-1:0] acc;

  assign wr_ent   = '{func: op_func, a: op_a, b: op_b, chain: op_chain};
  assign head     = entry_t'(head_raw);
  assign op_ready = !full;
  assign busy     = !empty || (state != S_IDLE);
  assign acc_out  = acc;

  // A pop may happen from IDLE, or from OUT on the same edge the result is taken.
  assign pop = ena && !empty &&
               ((state == S_IDLE) || ((state == S_OUT) && res_ready));

  alu_seq_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (op_valid && op_ready),
    .wr_data (EW'(wr_ent)),
    .rd_en   (pop),
    .rd_data (head_raw),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_func  <= FN_PASS;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      acc       <= '0;
      ops_done  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            alu_a    <= head.chain ? acc : head.a;
            alu_b    <= head.b;
            alu_func <= head.func;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data  <= alu_y;
          res_flags <= alu_flags;
          acc       <= alu_y;
          res_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
            if (pop) begin
              // acc already holds the result being handed off, so chaining sees it.
              alu_a    <= head.chain ? acc : head.a;
              alu_b    <= head.b;
              alu_func <= head.func;
              state    <= S_EXEC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the external ALU, predicts results per accepted
// op in a queue, and a negedge monitor checks every result hand-off.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_func = 4'h0;
  logic [3:0] op_a = 4'h0;
  logic [3:0] op_b = 4'h0;
  logic       op_chain = 1'b0;
  logic [3:0] alu_a, alu_b, alu_func, alu_y, alu_flags;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data, res_flags, acc_out;
  logic       busy;
  logic [7:0] ops_done;

  alu_op_sequencer #(.DW(4), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .op_valid(op_valid), .op_ready(op_ready), .op_func(op_func),
    .op_a(op_a), .op_b(op_b), .op_chain(op_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .acc_out(acc_out), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int handoffs = 0;
  int last_hand = 0;
  bit have_last = 0;
  bit tput_on = 0;
  bit prev_stall = 0;
  logic [7:0] prev_word;
  logic [7:0] exp_q[$];
  logic [3:0] m_acc = 4'h0;

  always @(posedge clk) cyc++;

  // Returns {Z,N,C,V,y}; C on SUB means no borrow.
  function automatic logic [7:0] alu_ref(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] y;
    logic c, v;
    s = 5'd0; c = 1'b0; v = 1'b0;
    case (f)
      FN_ADD: begin s = {1'b0, a} + {1'b0, b}; y = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (y[3] != a[3]); end
      FN_SUB: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; y = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (y[3] != a[3]); end
      FN_AND: y = a & b;
      FN_OR:  y = a | b;
      FN_XOR: y = a ^ b;
      FN_SLL: y = a << b[1:0];
      FN_SRL: y = a >> b[1:0];
      FN_SRA: y = $unsigned($signed(a) >>> b[1:0]);
      default: y = a;
    endcase
    return {(y == 4'h0), y[3], c, v, y};
  endfunction

  always_comb {alu_flags, alu_y} = alu_ref(alu_func, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Results come out in acceptance order; a chained op sees the previous op's result.
  function automatic void model_push(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b, input logic ch);
    logic [7:0] r;
    r = alu_ref(f, ch ? m_acc : a, b);
    m_acc = r[3:0];
    exp_q.push_back(r);
  endfunction

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      prev_stall = 0;
      handoffs = 0;
      have_last = 0;
    end else begin
      if (!tput_on) have_last = 0;
      if (prev_stall) begin
        check("stall_valid", res_valid, 1);
        check("stall_data", {res_flags, res_data}, prev_word);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", res_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e[3:0]);
          check("res_flags", res_flags, e[7:4]);
        end
        check("ops_done", ops_done, handoffs % 256);
        if (tput_on && have_last) check("tput_interval", cyc - last_hand, 2);
        last_hand = cyc;
        have_last = 1;
        handoffs++;
      end
      prev_stall = res_valid && !res_ready;
      prev_word = {res_flags, res_data};
    end
  end

  task automatic send(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b, input logic ch);
    int t;
    t = 0;
    op_func = f; op_a = a; op_b = b; op_chain = ch; op_valid = 1'b1;
    @(negedge clk);
    while (!op_ready && t < 200) begin @(negedge clk); t++; end
    if (op_ready) model_push(f, a, b, ch);
    else check("send_timeout", op_ready, 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_hand(input int target, input string name);
    int t;
    t = 0;
    while (handoffs < target && t < 200) begin @(posedge clk); t++; end
    #1;
    check(name, handoffs, target);
  endtask

  localparam logic [3:0] FUNCS [9] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLL, FN_SRL, FN_SRA, FN_PASS};

  initial begin
    int acc_n;
    int h0;
    bit accepted;
    logic [3:0] f;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_flags", res_flags, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_func", alu_func, FN_PASS);
    check("rst_acc", acc_out, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_op_ready", op_ready, 1);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    ena = 1'b1; res_ready = 1'b1;

    // ADD 3+5: latency of two edges from accept
    op_func = FN_ADD; op_a = 4'd3; op_b = 4'd5; op_chain = 1'b0; op_valid = 1'b1;
    @(negedge clk);
    check("lat_accept_ready", op_ready, 1);
    model_push(FN_ADD, 4'd3, 4'd5, 1'b0);
    @(posedge clk); #1; op_valid = 1'b0;
    check("lat_e0_valid", res_valid, 0);
    @(posedge clk); #1;
    check("lat_e1_valid", res_valid, 0);
    @(posedge clk); #1;
    check("lat_e2_valid", res_valid, 1);
    check("lat_e2_data", res_data, 4'b1000);
    check("lat_e2_flags", res_flags, 4'b0101);
    @(posedge clk); #1;
    check("lat_ops_done", ops_done, 1);

    // SUB 5-5 -> zero result, accumulator zero
    send(FN_SUB, 4'd5, 4'd5, 1'b0);
    wait_hand(2, "sub_wait");
    check("sub_acc", acc_out, 0);

    // Chained op uses the accumulator
    send(FN_ADD, 4'd2, 4'd3, 1'b0);
    send(FN_SUB, 4'hF, 4'd1, 1'b1);
    wait_hand(4, "chain_wait");
    check("chain_alu_a", alu_a, 4'b0101);
    check("chain_alu_func", alu_func, FN_SUB);
    check("chain_acc", acc_out, 4'b0100);

    // Capacity with stalled consumer, then throughput on release
    res_ready = 1'b0;
    acc_n = 0;
    h0 = handoffs;
    for (int i = 0; i < 6; i++) begin
      op_func = FUNCS[$urandom_range(0, 8)]; op_a = 4'($urandom); op_b = 4'($urandom);
      op_chain = 1'($urandom); op_valid = 1'b1;
      @(negedge clk);
      if (op_ready) begin acc_n++; model_push(op_func, op_a, op_b, op_chain); end
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    check("cap_accepted", acc_n, 5);
    check("cap_op_ready", op_ready, 0);
    check("cap_res_valid", res_valid, 1);
    tput_on = 1;
    res_ready = 1'b1;
    wait_hand(h0 + 5, "cap_drain");
    tput_on = 0;

    // ena low blocks pop but not queueing
    ena = 1'b0;
    h0 = handoffs;
    send(FN_XOR, 4'hA, 4'h6, 1'b0);
    send(FN_SLL, 4'h3, 4'h2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("ena_busy", busy, 1);
    check("ena_no_result", res_valid, 0);
    check("ena_ops_done", ops_done, h0 % 256);
    ena = 1'b1;
    wait_hand(h0 + 2, "ena_drain");
    check("ena_busy_drop", busy, 0);

    // Reset while in EXEC with three queued
    ena = 1'b0;
    for (int i = 0; i < 4; i++) send(FUNCS[$urandom_range(0, 8)], 4'($urandom), 4'($urandom), 1'b0);
    ena = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_acc = 4'h0;
    check("mrst_res_valid", res_valid, 0);
    check("mrst_acc", acc_out, 0);
    check("mrst_op_ready", op_ready, 1);
    check("mrst_ops_done", ops_done, 0);
    check("mrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mrst_no_stale", res_valid, 0);
    check("mrst_idle", busy, 0);

    // Randomized traffic with random ena and res_ready
    for (int c = 0; c < 400; c++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      ena = ($urandom_range(0, 4) != 0);
      if (!op_valid && $urandom_range(0, 1) == 1) begin
        f = ($urandom_range(0, 7) == 0) ? 4'($urandom) : FUNCS[$urandom_range(0, 8)];
        op_func = f; op_a = 4'($urandom); op_b = 4'($urandom);
        op_chain = 1'($urandom); op_valid = 1'b1;
      end
      @(negedge clk);
      accepted = op_valid && op_ready;
      if (accepted) model_push(op_func, op_a, op_b, op_chain);
      @(posedge clk); #1;
      if (accepted) op_valid = 1'b0;
    end
    op_valid = 1'b0; ena = 1'b1; res_ready = 1'b1;
    begin
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 300) begin @(posedge clk); t++; end
      #1;
    end
    check("rand_drained", exp_q.size(), 0);
    check("rand_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
